// File: rtl/apu_length_counter.sv
// rtl/apu_length_counter.sv - APU channel length counter with enable latch and zero flag
// Optional APU_LEN_STATUS_EN adds the R4015 status read register.
module apu_length_counter #(
   parameter int ENABLE_BIT = 2
) (
   input  logic       ACLK1,
   input  logic       n_RES,
   input  logic [7:0] DB,
   input  logic       W400B,
   input  logic       W4015,
   input  logic       nLFO2,
   input  logic       TRI_LC,
`ifdef APU_LEN_STATUS_EN
   input  logic       R4015,
   output logic       LEN_STATUS,
`endif
   output logic       NOTRI
);

   logic       en;
   logic [7:0] cnt;
   logic [7:0] cnt_next;
   logic [7:0] lut_value;
   logic       disable_now;
   logic       load_now;
   logic       step_now;

   always_comb begin
      lut_value = 8'd0;
      case (DB[7:3])
         5'd0:  lut_value = 8'd10;
         5'd1:  lut_value = 8'd254;
         5'd2:  lut_value = 8'd20;
         5'd3:  lut_value = 8'd2;
         5'd4:  lut_value = 8'd40;
         5'd5:  lut_value = 8'd4;
         5'd6:  lut_value = 8'd80;
         5'd7:  lut_value = 8'd6;
         5'd8:  lut_value = 8'd160;
         5'd9:  lut_value = 8'd8;
         5'd10: lut_value = 8'd60;
         5'd11: lut_value = 8'd10;
         5'd12: lut_value = 8'd14;
         5'd13: lut_value = 8'd12;
         5'd14: lut_value = 8'd26;
         5'd15: lut_value = 8'd14;
         5'd16: lut_value = 8'd12;
         5'd17: lut_value = 8'd16;
         5'd18: lut_value = 8'd24;
         5'd19: lut_value = 8'd18;
         5'd20: lut_value = 8'd48;
         5'd21: lut_value = 8'd20;
         5'd22: lut_value = 8'd96;
         5'd23: lut_value = 8'd22;
         5'd24: lut_value = 8'd192;
         5'd25: lut_value = 8'd24;
         5'd26: lut_value = 8'd72;
         5'd27: lut_value = 8'd26;
         5'd28: lut_value = 8'd16;
         5'd29: lut_value = 8'd28;
         5'd30: lut_value = 8'd32;
         5'd31: lut_value = 8'd30;
         default: lut_value = 8'd0;
      endcase
   end

   // Load is qualified by the enable held before this edge, so enable+load together is ignored.
   always_comb begin
      disable_now = (W4015 && !DB[ENABLE_BIT]) || !en;
      load_now    = W400B && en;
      step_now    = !nLFO2 && TRI_LC && (cnt != 8'd0);
      cnt_next    = cnt;
      if (disable_now)
         cnt_next = 8'd0;
      else if (load_now)
         cnt_next = lut_value;
      else if (step_now)
         cnt_next = cnt - 8'd1;
   end

   always_ff @(posedge ACLK1 or negedge n_RES) begin
      if (!n_RES) begin
         en  <= 1'b0;
         cnt <= 8'd0;
      end else begin
         if (W4015)
            en <= DB[ENABLE_BIT];
         cnt <= cnt_next;
      end
   end

   assign NOTRI = (cnt == 8'd0);

`ifdef APU_LEN_STATUS_EN
   always_ff @(posedge ACLK1 or negedge n_RES) begin
      if (!n_RES)
         LEN_STATUS <= 1'b0;
      else if (R4015)
         LEN_STATUS <= (cnt != 8'd0);
   end
`endif

endmodule

// File: tb/tb_apu_length_counter.sv
// tb/tb_apu_length_counter.sv - self-checking bench for apu_length_counter
// Covers APU_LEN_STATUS_EN when the macro is defined for both files.
module tb_apu_length_counter;

   localparam int EB = 2;

   logic       ACLK1 = 1'b0;
   logic       n_RES = 1'b0;
   logic [7:0] DB = 8'd0;
   logic       W400B = 1'b0;
   logic       W4015 = 1'b0;
   logic       nLFO2 = 1'b1;
   logic       TRI_LC = 1'b1;
   logic       R4015 = 1'b0;
   logic       LEN_STATUS;
   logic       NOTRI;

   int n_cmp = 0;
   int n_err = 0;

   int lut [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                    12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
   int en_m = 0;
   int cnt_m = 0;
   int st_m = 0;

   always #5 ACLK1 = ~ACLK1;

   apu_length_counter #(.ENABLE_BIT(EB)) dut (
      .ACLK1(ACLK1),
      .n_RES(n_RES),
      .DB(DB),
      .W400B(W400B),
      .W4015(W4015),
      .nLFO2(nLFO2),
      .TRI_LC(TRI_LC),
`ifdef APU_LEN_STATUS_EN
      .R4015(R4015),
      .LEN_STATUS(LEN_STATUS),
`endif
      .NOTRI(NOTRI)
   );

`ifndef APU_LEN_STATUS_EN
   assign LEN_STATUS = 1'b0;
`endif

   // One clock with the given strobes; the model applies the channel rules to the pre-edge state.
   task automatic tick(input logic w15, input logic w0b, input logic [7:0] db,
                       input logic pulse, input logic tl, input logic rd);
      int was_en;
      int was_cnt;
      W4015 = w15; W400B = w0b; DB = db; nLFO2 = !pulse; TRI_LC = tl; R4015 = rd;
      @(posedge ACLK1);
      was_en = en_m;
      was_cnt = cnt_m;
      if (w15) en_m = db[EB];
      if (was_en == 0 || (w15 && !db[EB])) cnt_m = 0;
      else if (w0b) cnt_m = lut[db[7:3]];
      else if (pulse && tl) cnt_m = (was_cnt > 0) ? was_cnt - 1 : 0;
      if (rd) st_m = (was_cnt != 0);
      #1;
      W4015 = 1'b0; W400B = 1'b0; nLFO2 = 1'b1; R4015 = 1'b0;
   endtask

   task automatic test_reset;
      n_RES = 1'b0;
      #2;
      n_cmp++;
      if (NOTRI !== 1'b1) begin
         n_err++; $display("FAIL reset_notri: got %b want 1", NOTRI);
      end
      n_cmp++;
      if (LEN_STATUS !== 1'b0) begin
         n_err++; $display("FAIL reset_status: got %b want 0", LEN_STATUS);
      end
      @(negedge ACLK1);
      n_RES = 1'b1;
      en_m = 0; cnt_m = 0; st_m = 0;
      tick(1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (NOTRI !== 1'b1) begin
         n_err++; $display("FAIL load_while_disabled: got %b want 1", NOTRI);
      end
   endtask

   task automatic test_enable_load;
      logic want [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      tick(1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 8'h18, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (NOTRI !== want[0]) begin
         n_err++; $display("FAIL load_idx3: got %b want %b", NOTRI, want[0]);
      end
      for (int i = 1; i < 4; i++) begin
         tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         n_cmp++;
         if (NOTRI !== want[i]) begin
            n_err++; $display("FAIL step_pulse%0d: got %b want %b", i, NOTRI, want[i]);
         end
      end
   endtask

   task automatic test_halt;
      int steps;
      tick(1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         tick(1'b0, 1'b0, 8'h00, 1'b0, (i % 2 == 0), 1'b0);
      end
      n_cmp++;
      if (NOTRI !== 1'b0) begin
         n_err++; $display("FAIL halt_hold: got %b want 0", NOTRI);
      end
      steps = 0;
      while (NOTRI === 1'b0 && steps < 300) begin
         tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         steps++;
      end
      n_cmp++;
      if (steps != 254) begin
         n_err++; $display("FAIL halt_release_steps: got %0d want 254", steps);
      end
   endtask

   task automatic test_collision;
      int steps;
      tick(1'b0, 1'b1, 8'h38, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
      steps = 0;
      while (NOTRI === 1'b0 && steps < 30) begin
         tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         steps++;
      end
      n_cmp++;
      if (steps != 10) begin
         n_err++; $display("FAIL collision_steps: got %0d want 10", steps);
      end
   endtask

   task automatic test_disable;
      tick(1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (NOTRI !== 1'b0) begin
         n_err++; $display("FAIL load_160: got %b want 0", NOTRI);
      end
      tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (NOTRI !== 1'b1) begin
         n_err++; $display("FAIL disable_clear: got %b want 1", NOTRI);
      end
      tick(1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (NOTRI !== 1'b1) begin
         n_err++; $display("FAIL load_after_disable: got %b want 1", NOTRI);
      end
      tick(1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (NOTRI !== 1'b1) begin
         n_err++; $display("FAIL enable_and_load: got %b want 1", NOTRI);
      end
   endtask

   task automatic test_async_reset;
      tick(1'b0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
      #1;
      n_RES = 1'b0;
      #1;
      n_cmp++;
      if (NOTRI !== 1'b1) begin
         n_err++; $display("FAIL async_reset_midcount: got %b want 1", NOTRI);
      end
      @(negedge ACLK1);
      n_RES = 1'b1;
      en_m = 0; cnt_m = 0; st_m = 0;
      tick(1'b0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (NOTRI !== 1'b1) begin
         n_err++; $display("FAIL reset_clears_enable: got %b want 1", NOTRI);
      end
   endtask

   task automatic test_status;
`ifdef APU_LEN_STATUS_EN
      tick(1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 8'h18, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (LEN_STATUS !== 1'b1) begin
         n_err++; $display("FAIL status_nonzero: got %b want 1", LEN_STATUS);
      end
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (LEN_STATUS !== 1'b1) begin
         n_err++; $display("FAIL status_hold: got %b want 1", LEN_STATUS);
      end
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (LEN_STATUS !== 1'b0) begin
         n_err++; $display("FAIL status_zero: got %b want 0", LEN_STATUS);
      end
`endif
   endtask

   task automatic test_random;
      logic w15, w0b, pulse, tl, rd;
      logic [7:0] db;
      for (int i = 0; i < 600; i++) begin
         w15   = ($urandom_range(0, 15) == 0);
         w0b   = ($urandom_range(0, 9) == 0);
         pulse = ($urandom_range(0, 2) == 0);
         tl    = ($urandom_range(0, 5) != 0);
         rd    = ($urandom_range(0, 7) == 0);
         db    = 8'($urandom);
         if (w15 && $urandom_range(0, 2) != 0) db[EB] = 1'b1;
         tick(w15, w0b, db, pulse, tl, rd);
         n_cmp++;
         if (NOTRI !== (cnt_m == 0)) begin
            n_err++; $display("FAIL random_notri[%0d]: got %b want %b", i, NOTRI, (cnt_m == 0));
         end
`ifdef APU_LEN_STATUS_EN
         n_cmp++;
         if (LEN_STATUS !== st_m[0]) begin
            n_err++; $display("FAIL random_status[%0d]: got %b want %b", i, LEN_STATUS, st_m[0]);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_enable_load();
      test_halt();
      test_collision();
      test_disable();
      test_async_reset();
      test_status();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
